// File: rtl/skeleton_ram_bist_pkg.sv
// Shared types and helpers for the multi-bank RAM skeleton with built-in self-test.
package ram_skeleton_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAN_ACC,
    S_MAN_OUT,
    S_BIST_WR,
    S_BIST_RD,
    S_BIST_FLUSH,
    S_BIST_DONE
  } state_t;

  localparam logic [3:0] HEAD_TYPE_ID = 4'd5;
  localparam int         MAX_BANKS    = 4;
  localparam int         BANK_W       = 2;

  // Pass 1 writes the complement so every cell sees both polarities.
  function automatic logic [30:0] bist_pattern(input logic [30:0] seed,
                                               input logic [30:0] index,
                                               input logic        pass);
    logic [30:0] p;
    p = seed ^ index;
    return pass ? ~p : p;
  endfunction

endpackage

// File: rtl/skeleton_ram_bist_if.sv
// Host-side control/data bus of the RAM skeleton; master = host, slave = skeleton.
interface skeleton_ram_bist_if #(
  parameter int BITWIDTH_IN   = 12,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 26,
  parameter int BITWIDTH_ADR  = 6
);
  logic                     EN;
  logic                     TRGG_START_CALC;
  logic                     MODE;
  logic                     RnW;
  logic [1:0]               BANK_SEL;
  logic [BITWIDTH_ADR-1:0]  ADR;
  logic [BITWIDTH_SYS-1:0]  DATA_IN;
  logic [BITWIDTH_SYS-1:0]  DATA_OUT;
  logic [BITWIDTH_HEAD-1:0] DATA_HEAD;
  logic                     RDY;
  logic                     ERR;

  modport master (
    output EN, TRGG_START_CALC, MODE, RnW, BANK_SEL, ADR, DATA_IN,
    input  DATA_OUT, DATA_HEAD, RDY, ERR
  );

  modport slave (
    input  EN, TRGG_START_CALC, MODE, RnW, BANK_SEL, ADR, DATA_IN,
    output DATA_OUT, DATA_HEAD, RDY, ERR
  );
endinterface

// File: rtl/skeleton_ram_bist_bram.sv
// Single-port block RAM bank with registered read data (1-cycle latency), no reset on contents.
module bram_single #(
  parameter int DW = 12,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[adr] <= din;
      else    rd_q     <= mem[adr];
    end
  end

  assign dout = rd_q;

endmodule

// File: rtl/skeleton_ram_bist.sv
// Multi-bank RAM skeleton: handshaked manual word access plus a two-pass write/read-compare BIST.
module skeleton_ram_bist
  import ram_skeleton_pkg::*;
#(
  parameter int BITWIDTH_IN   = 12,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 26,
  parameter int BITWIDTH_ADR  = 6,
  parameter int NUM_BANKS     = 2
) (
  input logic                CLK_SYS,
  input logic                RSTN,
  skeleton_ram_bist_if.slave bus
);

  localparam int IN    = BITWIDTH_IN;
  localparam int SYS   = BITWIDTH_SYS;
  localparam int AW    = BITWIDTH_ADR;
  localparam int NB    = (NUM_BANKS > MAX_BANKS) ? MAX_BANKS : NUM_BANKS;
  localparam int IDX_W = AW + BANK_W;
  localparam int WORDS = NB * (2**AW);

  state_t state_q, state_d;

  logic [BANK_W-1:0] bank_q, bank_d_q;
  logic [AW-1:0]     adr_q;
  logic [IN-1:0]     din_q;
  logic              rnw_q;
  logic [IDX_W-1:0]  idx_q, cmp_idx_q;
  logic              pass_q, cmp_pend_q;
  logic [SYS-1:0]    cnt_q, data_out_q;
  logic              err_q;

  logic              accept, idx_last, rdy;
  logic              acc_en, acc_we;
  logic [BANK_W-1:0] acc_bank;
  logic [AW-1:0]     acc_adr;
  logic [IN-1:0]     acc_wdata;
  logic [IN-1:0]     rd_data, wr_pattern, exp_word;
  logic              mismatch;
  logic              unused_din;

  logic [NB-1:0]     bank_en;
  logic [IN-1:0]     bank_dout [NB];

  assign accept     = (state_q == S_IDLE) && bus.EN && bus.TRGG_START_CALC;
  assign idx_last   = (idx_q == IDX_W'(WORDS - 1));
  assign wr_pattern = IN'(bist_pattern(31'(din_q), 31'(idx_q), pass_q));
  assign exp_word   = IN'(bist_pattern(31'(din_q), 31'(cmp_idx_q), pass_q));
  assign mismatch   = cmp_pend_q && (rd_data != exp_word);
  assign unused_din = ^bus.DATA_IN;

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = bus.MODE ? S_BIST_WR : S_MAN_ACC;
      S_MAN_ACC:    state_d = S_MAN_OUT;
      S_MAN_OUT:    state_d = S_IDLE;
      S_BIST_WR:    if (idx_last) state_d = S_BIST_RD;
      S_BIST_RD:    if (idx_last) state_d = S_BIST_FLUSH;
      S_BIST_FLUSH: state_d = pass_q ? S_BIST_DONE : S_BIST_WR;
      S_BIST_DONE:  state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy       = 1'b0;
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_bank  = bank_q;
    acc_adr   = adr_q;
    acc_wdata = din_q;
    case (state_q)
      S_IDLE:    rdy = 1'b1;
      S_MAN_ACC: begin
        acc_en = (32'(bank_q) < NB);
        acc_we = rnw_q;
      end
      S_BIST_WR, S_BIST_RD: begin
        acc_en    = 1'b1;
        acc_we    = (state_q == S_BIST_WR);
        acc_bank  = idx_q[IDX_W-1 -: BANK_W];
        acc_adr   = idx_q[AW-1:0];
        acc_wdata = wr_pattern;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      bank_q     <= '0;
      adr_q      <= '0;
      din_q      <= '0;
      rnw_q      <= 1'b0;
      idx_q      <= '0;
      cmp_idx_q  <= '0;
      pass_q     <= 1'b0;
      cmp_pend_q <= 1'b0;
      bank_d_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        bank_q <= bus.BANK_SEL;
        adr_q  <= bus.ADR;
        din_q  <= bus.DATA_IN[SYS-1 -: IN];
        rnw_q  <= bus.RnW;
      end

      if (state_q == S_BIST_WR || state_q == S_BIST_RD)
        idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
      else
        idx_q <= '0;

      if (accept)                       pass_q <= 1'b0;
      else if (state_q == S_BIST_FLUSH) pass_q <= 1'b1;

      // Compare runs one cycle behind the read issue to match BRAM latency.
      cmp_pend_q <= (state_q == S_BIST_RD);
      cmp_idx_q  <= idx_q;
      bank_d_q   <= acc_bank;

      if (accept && bus.MODE)             cnt_q <= '0;
      else if (mismatch && (cnt_q != '1)) cnt_q <= cnt_q + SYS'(1);

      if (state_q == S_MAN_OUT && !rnw_q)
        data_out_q <= SYS'(rd_data) << (SYS - IN);
      else if (state_q == S_BIST_DONE)
        data_out_q <= cnt_q;

      if (state_q == S_BIST_DONE) err_q <= (cnt_q != '0);
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign bank_en[b] = acc_en && (acc_bank == BANK_W'(b));
    bram_single #(.DW(IN), .AW(AW)) u_bram (
      .clk  (CLK_SYS),
      .en   (bank_en[b]),
      .we   (acc_we),
      .adr  (acc_adr),
      .din  (acc_wdata),
      .dout (bank_dout[b])
    );
  end

  // Out-of-range bank selects fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NB; b++)
      if (bank_d_q == BANK_W'(b)) rd_data = bank_dout[b];
  end

  assign bus.DATA_OUT  = data_out_q;
  assign bus.RDY       = rdy;
  assign bus.ERR       = err_q;
  assign bus.DATA_HEAD = BITWIDTH_HEAD'({HEAD_TYPE_ID, 6'(BITWIDTH_ADR), 2'(NB - 1), 4'd0,
                                         5'(BITWIDTH_IN), 5'(BITWIDTH_IN)});

endmodule

// File: tb/tb_skeleton_ram_bist.sv
// Directed bench for skeleton_ram_bist: manual access vector table plus BIST/reset sequences.
module tb_skeleton_ram_bist;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   fault_on = 1'b0;

  always #5 clk = ~clk;

  skeleton_ram_bist_if #(.BITWIDTH_IN(12), .BITWIDTH_SYS(16), .BITWIDTH_HEAD(26),
                         .BITWIDTH_ADR(6)) bus ();

  skeleton_ram_bist #(.BITWIDTH_IN(12), .BITWIDTH_SYS(16), .BITWIDTH_HEAD(26),
                      .BITWIDTH_ADR(6), .NUM_BANKS(2)) dut (
    .CLK_SYS (clk),
    .RSTN    (rstn),
    .bus     (bus)
  );

  typedef struct {
    bit          en;
    bit          rnw;
    logic [1:0]  bank;
    logic [5:0]  adr;
    logic [15:0] din;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pat(input logic [11:0] seed, input int i, input bit pass);
    logic [11:0] p;
    p = seed ^ 12'(i);
    return pass ? ~p : p;
  endfunction

  task automatic trig(input bit en, input bit mode, input bit rnw, input logic [1:0] bank,
                      input logic [5:0] adr, input logic [15:0] din);
    @(negedge clk);
    bus.EN = en; bus.MODE = mode; bus.RnW = rnw;
    bus.BANK_SEL = bank; bus.ADR = adr; bus.DATA_IN = din;
    bus.TRGG_START_CALC = 1'b1;
    @(negedge clk);
    bus.TRGG_START_CALC = 1'b0;
    bus.EN = 1'b1;
    // Scramble inputs after the accept edge; the operation must use latched values.
    bus.ADR = ~adr; bus.DATA_IN = ~din; bus.BANK_SEL = bank ^ 2'b01; bus.RnW = ~rnw;
  endtask

  task automatic man_read(input logic [1:0] bank, input logic [5:0] adr, output logic [15:0] d);
    trig(1'b1, 1'b0, 1'b0, bank, adr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    d = bus.DATA_OUT;
  endtask

  task automatic run_bist(input logic [15:0] seed, input bit poke, output int cyc);
    trig(1'b1, 1'b1, 1'b0, 2'd0, 6'd0, seed);
    cyc = 0;
    while (!bus.RDY && cyc < 700) begin
      cyc++;
      if (poke && cyc >= 100 && cyc < 103) begin
        bus.MODE = 1'b0; bus.RnW = 1'b1; bus.BANK_SEL = 2'd1;
        bus.ADR = 6'd0; bus.DATA_IN = 16'hFFF0; bus.TRGG_START_CALC = 1'b1;
      end else begin
        bus.TRGG_START_CALC = 1'b0;
      end
      @(negedge clk);
    end
    bus.TRGG_START_CALC = 1'b0;
  endtask

  // Re-applied every cycle so the forced value tracks the bank's real read data.
  initial begin
    forever begin
      @(negedge clk);
      if (fault_on)
        force dut.g_bank[0].u_bram.dout = dut.g_bank[0].u_bram.rd_q | 12'h001;
    end
  end

  initial begin
    int          cyc;
    int          exp_cnt;
    logic [15:0] rd;
    logic [25:0] exp_head;

    bus.EN = 1'b1; bus.TRGG_START_CALC = 1'b0; bus.MODE = 1'b0; bus.RnW = 1'b0;
    bus.BANK_SEL = 2'd0; bus.ADR = 6'd0; bus.DATA_IN = 16'h0000;

    vecs[0]  = '{1'b1, 1'b1, 2'd0, 6'd63, 16'h1230, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 6'd63, 16'hABC0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 6'd63, 16'h0000, 16'hABC0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 6'd63, 16'h0000, 16'h1230};
    vecs[4]  = '{1'b1, 1'b1, 2'd3, 6'd5,  16'hFFF0, 16'h1230};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 6'd5,  16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 6'd5,  16'h7770, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 6'd5,  16'h1110, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 6'd5,  16'h0000, 16'h7770};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 6'd0,  16'h5A5F, 16'h7770};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 6'd0,  16'h0000, 16'h5A50};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 6'd63, 16'h0000, 16'h5A50};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 6'd63, 16'h0000, 16'h0000};

    exp_head = {4'd5, 6'd6, 2'd1, 4'd0, 5'd12, 5'd12};

    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(bus.RDY), 32'd1);
    check("reset_data_out", 32'(bus.DATA_OUT), 32'd0);
    check("reset_err", 32'(bus.ERR), 32'd0);
    check("data_head", 32'(bus.DATA_HEAD), 32'(exp_head));
    rstn = 1'b1;

    for (int v = 0; v < 13; v++) begin
      trig(vecs[v].en, 1'b0, vecs[v].rnw, vecs[v].bank, vecs[v].adr, vecs[v].din);
      check($sformatf("vec%0d_rdy_busy", v), 32'(bus.RDY), 32'(!vecs[v].en));
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_rdy_done", v), 32'(bus.RDY), 32'd1);
      check($sformatf("vec%0d_data_out", v), 32'(bus.DATA_OUT), 32'(vecs[v].exp_out));
    end

    run_bist(16'h5A50, 1'b0, cyc);
    check("clean_bist_cycles", 32'(cyc), 32'd515);
    check("clean_bist_count", 32'(bus.DATA_OUT), 32'd0);
    check("clean_bist_err", 32'(bus.ERR), 32'd0);

    // Bank 0 bit 0 stuck at 1: mismatch wherever the expected bit 0 is 0.
    exp_cnt = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 64; i++)
        if (pat(12'h3C7, i, p[0]) [0] == 1'b0) exp_cnt++;
    fault_on = 1'b1;
    run_bist(16'h3C70, 1'b1, cyc);
    fault_on = 1'b0;
    release dut.g_bank[0].u_bram.dout;
    check("fault_bist_cycles", 32'(cyc), 32'd515);
    check("fault_bist_count", 32'(bus.DATA_OUT), 32'(exp_cnt));
    check("fault_bist_err", 32'(bus.ERR), 32'd1);

    man_read(2'd1, 6'd0, rd);
    check("bist_contents_b1a0", 32'(rd), 32'({pat(12'h3C7, 64, 1'b1), 4'h0}));
    man_read(2'd0, 6'd3, rd);
    check("bist_contents_b0a3", 32'(rd), 32'({pat(12'h3C7, 3, 1'b1), 4'h0}));

    trig(1'b1, 1'b1, 1'b0, 2'd0, 6'd0, 16'h5A50);
    repeat (199) @(negedge clk);
    check("mid_bist_busy", 32'(bus.RDY), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_reset_rdy", 32'(bus.RDY), 32'd1);
    check("mid_reset_err", 32'(bus.ERR), 32'd0);
    check("mid_reset_data_out", 32'(bus.DATA_OUT), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_bist(16'h5A50, 1'b0, cyc);
    check("rerun_bist_cycles", 32'(cyc), 32'd515);
    check("rerun_bist_count", 32'(bus.DATA_OUT), 32'd0);
    check("rerun_bist_err", 32'(bus.ERR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
